// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit: stage indices, one-hot
// stall/flush request codes and the multiply/divide sequencer state type.
package mips_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam logic [4:0] STALL_IF  = 5'(1 << STG_IF);
  localparam logic [4:0] STALL_ID  = 5'(1 << STG_ID);
  localparam logic [4:0] STALL_MEM = 5'(1 << STG_MEM);
  localparam logic [4:0] FLUSH_ID  = 5'(1 << STG_ID);
  localparam logic [4:0] FLUSH_MEM = 5'(1 << STG_MEM);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Raw hazard conditions before stall selection and flush priority.
  typedef struct packed {
    logic imem;
    logic load_use;
    logic md;
    logic dmem;
  } hazard_causes_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of pipeline status inputs and stall/flush/md outputs exchanged
// between the pipeline datapath (master) and the hazard unit (slave).
interface hazard_unit_if;

  logic       imem_ready;
  logic       dmem_ready;
  logic       mem_access;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_hilo_use;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_md_start;
  logic       ex_md_is_div;
  logic       ex_branch_taken;
  logic       mem_exception;
  logic [4:0] stall;
  logic [4:0] flush;
  logic       md_busy;
  logic       md_done;

  modport master (
    output imem_ready, dmem_ready, mem_access,
    output id_rs, id_rt, id_use_rs, id_use_rt, id_hilo_use,
    output ex_mem_read, ex_rd, ex_md_start, ex_md_is_div, ex_branch_taken,
    output mem_exception,
    input  stall, flush, md_busy, md_done
  );

  modport slave (
    input  imem_ready, dmem_ready, mem_access,
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_hilo_use,
    input  ex_mem_read, ex_rd, ex_md_start, ex_md_is_div, ex_branch_taken,
    input  mem_exception,
    output stall, flush, md_busy, md_done
  );

endinterface

// File: rtl/hazard_unit_md_sequencer.sv
// Background multiply/divide sequencer: tracks the remaining latency of the
// active operation and pulses done in its final busy cycle.
module md_sequencer
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  input  logic abort,
  output logic busy,
  output logic done
);

  localparam int MAX_CYCLES = max_int(MULT_CYCLES, DIV_CYCLES);
  localparam int CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // The counter reaches zero on the edge that leaves BUSY, so the unit is
  // busy for exactly (latency - 1) cycles after the start is accepted.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done    = 1'b0;
    if (rst || abort) begin
      state_d = MD_IDLE;
      count_d = '0;
    end else if (start) begin
      state_d = MD_BUSY;
      count_d = is_div ? DIV_LOAD : MULT_LOAD;
    end else if (state_q == MD_BUSY) begin
      if (count_q <= CNT_ONE) begin
        state_d = MD_IDLE;
        count_d = '0;
        done    = 1'b1;
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard detection: raises per-stage stall/flush requests and
// sequences the multiply/divide unit so HI/LO readers wait for results.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_unit_if.slave hu
);

  hazard_causes_t cause;
  logic           dmem_wait;
  logic           md_start;
  logic           md_busy;
  logic           md_done;
  logic [4:0]     stall_req;
  logic [4:0]     stall;
  logic [4:0]     flush;

  assign dmem_wait = hu.mem_access && !hu.dmem_ready;
  assign md_start  = hu.ex_md_start && !dmem_wait;

  md_sequencer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_sequencer (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div (hu.ex_md_is_div),
    .abort  (hu.mem_exception),
    .busy   (md_busy),
    .done   (md_done)
  );

  always_comb begin
    cause          = '0;
    cause.imem     = !hu.imem_ready;
    cause.load_use = hu.ex_mem_read && (hu.ex_rd != 5'd0) &&
                     ((hu.id_use_rs && (hu.id_rs == hu.ex_rd)) ||
                      (hu.id_use_rt && (hu.id_rt == hu.ex_rd)));
    cause.md       = hu.id_hilo_use && md_busy;
    cause.dmem     = dmem_wait;
  end

  // Only the most downstream stall matters; upstream stages freeze behind it.
  always_comb begin
    stall_req = '0;
    if (cause.dmem) begin
      stall_req = STALL_MEM;
    end else if (cause.load_use || cause.md) begin
      stall_req = STALL_ID;
    end else if (cause.imem) begin
      stall_req = STALL_IF;
    end
  end

  // A taken branch waits behind a data-memory stall and re-resolves later.
  always_comb begin
    stall = stall_req;
    flush = '0;
    if (rst) begin
      stall = '0;
    end else if (hu.mem_exception) begin
      stall = '0;
      flush = FLUSH_MEM;
    end else if (hu.ex_branch_taken && !cause.dmem) begin
      stall = stall_req & ~(STALL_ID | STALL_IF);
      flush = FLUSH_ID;
    end
  end

  assign hu.stall   = stall;
  assign hu.flush   = flush;
  assign hu.md_busy = md_busy;
  assign hu.md_done = md_done;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by random
// traffic compared against a cycle-level behavioural model of the rules.
module tb_hazard_unit;

  localparam int MULT_CYCLES = 4;
  localparam int DIV_CYCLES  = 32;

  logic clk = 1'b0;
  logic rst;

  hazard_unit_if hu ();

  hazard_unit #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hu  (hu)
  );

  always #5 clk = ~clk;

  int total   = 0;
  int bad     = 0;
  int md_left = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic setDefaults();
    hu.imem_ready      = 1'b1;
    hu.dmem_ready      = 1'b1;
    hu.mem_access      = 1'b0;
    hu.id_rs           = 5'd0;
    hu.id_rt           = 5'd0;
    hu.id_use_rs       = 1'b0;
    hu.id_use_rt       = 1'b0;
    hu.id_hilo_use     = 1'b0;
    hu.ex_mem_read     = 1'b0;
    hu.ex_rd           = 5'd0;
    hu.ex_md_start     = 1'b0;
    hu.ex_md_is_div    = 1'b0;
    hu.ex_branch_taken = 1'b0;
    hu.mem_exception   = 1'b0;
  endtask

  // Compares one cycle against the model, advances the model, then returns
  // at the next falling edge so the caller can drive the following cycle.
  task automatic applyStimulus(input string tag);
    logic       dmem_stall, load_use, md_stall, imem_stall, start_ok;
    logic       exp_busy, exp_done;
    logic [4:0] exp_stall, exp_flush;
    #1;
    exp_busy   = (md_left > 0);
    dmem_stall = hu.mem_access && !hu.dmem_ready;
    load_use   = hu.ex_mem_read && (hu.ex_rd != 0) &&
                 ((hu.id_use_rs && hu.id_rs == hu.ex_rd) ||
                  (hu.id_use_rt && hu.id_rt == hu.ex_rd));
    md_stall   = hu.id_hilo_use && exp_busy;
    imem_stall = !hu.imem_ready;
    start_ok   = !rst && hu.ex_md_start && !dmem_stall && !hu.mem_exception;
    exp_stall  = 5'b00000;
    exp_flush  = 5'b00000;
    if (!rst) begin
      if (hu.mem_exception) begin
        exp_flush = 5'b01000;
      end else if (dmem_stall) begin
        exp_stall = 5'b01000;
      end else if (hu.ex_branch_taken) begin
        exp_flush = 5'b00010;
      end else if (load_use || md_stall) begin
        exp_stall = 5'b00010;
      end else if (imem_stall) begin
        exp_stall = 5'b00001;
      end
    end
    exp_done = !rst && !hu.mem_exception && !start_ok && (md_left == 1);
    checkOutput($sformatf("%s.stall", tag), 32'(hu.stall), 32'(exp_stall));
    checkOutput($sformatf("%s.flush", tag), 32'(hu.flush), 32'(exp_flush));
    checkOutput($sformatf("%s.busy", tag), 32'(hu.md_busy), 32'(exp_busy));
    checkOutput($sformatf("%s.done", tag), 32'(hu.md_done), 32'(exp_done));
    if (rst || hu.mem_exception) begin
      md_left = 0;
    end else if (start_ok) begin
      md_left = (hu.ex_md_is_div ? DIV_CYCLES : MULT_CYCLES) - 1;
    end else if (md_left > 0) begin
      md_left--;
    end
    @(negedge clk);
  endtask

  initial begin
    setDefaults();
    rst = 1'b1;
    @(negedge clk);
    applyStimulus("reset0");
    applyStimulus("reset1");
    rst = 1'b0;
    applyStimulus("idle");

    hu.ex_mem_read = 1'b1;
    hu.ex_rd       = 5'd8;
    hu.id_use_rs   = 1'b1;
    hu.id_rs       = 5'd8;
    #1;
    checkOutput("lu_stall", 32'(hu.stall), 32'h02);
    checkOutput("lu_flush", 32'(hu.flush), 32'h00);
    applyStimulus("lu");
    hu.ex_rd = 5'd0;
    hu.id_rs = 5'd0;
    #1;
    checkOutput("lu_r0_stall", 32'(hu.stall), 32'h00);
    applyStimulus("lu_r0");

    setDefaults();
    hu.ex_md_start = 1'b1;
    applyStimulus("mul_start");
    hu.ex_md_start = 1'b0;
    hu.id_hilo_use = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("mul_busy%0d", i), 32'(hu.md_busy), 32'(i < 3));
      checkOutput($sformatf("mul_done%0d", i), 32'(hu.md_done), 32'(i == 2));
      checkOutput($sformatf("mul_stall%0d", i), 32'(hu.stall), (i < 3) ? 32'h02 : 32'h00);
      applyStimulus("mul");
    end

    setDefaults();
    hu.ex_branch_taken = 1'b1;
    hu.imem_ready      = 1'b0;
    #1;
    checkOutput("br_flush", 32'(hu.flush), 32'h02);
    checkOutput("br_stall", 32'(hu.stall), 32'h00);
    applyStimulus("br");
    hu.mem_access = 1'b1;
    hu.dmem_ready = 1'b0;
    #1;
    checkOutput("br_dmem_stall", 32'(hu.stall), 32'h08);
    checkOutput("br_dmem_flush", 32'(hu.flush), 32'h00);
    applyStimulus("br_dmem");

    setDefaults();
    hu.ex_md_start  = 1'b1;
    hu.ex_md_is_div = 1'b1;
    applyStimulus("div_start");
    setDefaults();
    for (int i = 1; i < 5; i++) applyStimulus("div_run");
    hu.mem_exception = 1'b1;
    hu.id_hilo_use   = 1'b1;
    hu.imem_ready    = 1'b0;
    #1;
    checkOutput("exc_flush", 32'(hu.flush), 32'h08);
    checkOutput("exc_stall", 32'(hu.stall), 32'h00);
    applyStimulus("exc");
    setDefaults();
    #1;
    checkOutput("exc_busy_after", 32'(hu.md_busy), 32'h0);
    checkOutput("exc_done_after", 32'(hu.md_done), 32'h0);
    applyStimulus("exc_after");

    hu.ex_md_start  = 1'b1;
    hu.ex_md_is_div = 1'b1;
    applyStimulus("rdiv_start");
    setDefaults();
    for (int i = 0; i < 3; i++) applyStimulus("rdiv_run");
    rst                = 1'b1;
    hu.imem_ready      = 1'b0;
    hu.mem_access      = 1'b1;
    hu.dmem_ready      = 1'b0;
    hu.ex_mem_read     = 1'b1;
    hu.ex_rd           = 5'd5;
    hu.id_rs           = 5'd5;
    hu.id_use_rs       = 1'b1;
    hu.id_hilo_use     = 1'b1;
    hu.ex_branch_taken = 1'b1;
    hu.mem_exception   = 1'b1;
    #1;
    checkOutput("rst_stall", 32'(hu.stall), 32'h00);
    checkOutput("rst_flush", 32'(hu.flush), 32'h00);
    applyStimulus("rst_mid");
    rst = 1'b0;
    setDefaults();
    #1;
    checkOutput("rst_busy_after", 32'(hu.md_busy), 32'h0);
    applyStimulus("rst_after");

    hu.ex_md_start = 1'b1;
    hu.mem_access  = 1'b1;
    hu.dmem_ready  = 1'b0;
    applyStimulus("gate0");
    #1;
    checkOutput("gate_busy0", 32'(hu.md_busy), 32'h0);
    applyStimulus("gate1");
    hu.dmem_ready = 1'b1;
    #1;
    checkOutput("gate_busy1", 32'(hu.md_busy), 32'h0);
    applyStimulus("gate_go");
    setDefaults();
    #1;
    checkOutput("gate_started", 32'(hu.md_busy), 32'h1);
    for (int i = 0; i < 3; i++) applyStimulus("gate_run");

    for (int n = 0; n < 3000; n++) begin
      rst                = ($urandom_range(0, 99) < 2);
      hu.imem_ready      = ($urandom_range(0, 99) < 80);
      hu.mem_access      = ($urandom_range(0, 99) < 40);
      hu.dmem_ready      = ($urandom_range(0, 99) < 70);
      hu.id_rs           = 5'($urandom_range(0, 3));
      hu.id_rt           = 5'($urandom_range(0, 3));
      hu.id_use_rs       = 1'($urandom_range(0, 1));
      hu.id_use_rt       = 1'($urandom_range(0, 1));
      hu.id_hilo_use     = ($urandom_range(0, 99) < 30);
      hu.ex_mem_read     = ($urandom_range(0, 99) < 40);
      hu.ex_rd           = 5'($urandom_range(0, 3));
      hu.ex_md_start     = ($urandom_range(0, 99) < 8);
      hu.ex_md_is_div    = ($urandom_range(0, 99) < 30);
      hu.ex_branch_taken = ($urandom_range(0, 99) < 15);
      hu.mem_exception   = ($urandom_range(0, 99) < 3);
      applyStimulus("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
